// File: rtl/dma_pkg.sv
// Shared definitions for the parser-to-memory payload path.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } dma_state_t;

  localparam int PAYLOAD_WORDS = 10;
  localparam int DATA_W        = 32;

endpackage

// File: rtl/dma_ring_ctrl.sv
// Ring bookkeeping: which slot is being written next and how many filled
// slots the host has not yet released.
module dma_ring_ctrl #(
  parameter int RING_PKTS = 4,
  localparam int SLOT_W   = $clog2(RING_PKTS),
  localparam int CNT_W    = $clog2(RING_PKTS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance_i,
  input  logic              free_i,
  output logic [SLOT_W-1:0] wr_slot_o,
  output logic              ring_full_o
);

  logic [SLOT_W-1:0] wr_slot_q, wr_slot_d;
  logic [CNT_W-1:0]  outstanding_q, outstanding_d;
  logic              ring_full_q, ring_full_d;
  logic              free_ok;

  // Next-state for slot pointer and fill count; an ack on an empty ring is dropped.
  always_comb begin
    free_ok       = free_i && (outstanding_q != '0);
    outstanding_d = outstanding_q;
    wr_slot_d     = wr_slot_q;
    if (advance_i) begin
      // RING_PKTS is a power of two, so the pointer wraps naturally.
      wr_slot_d = wr_slot_q + SLOT_W'(1);
    end
    case ({advance_i, free_ok})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
    ring_full_d = (outstanding_d == CNT_W'(RING_PKTS));
  end

  // Ring state registers; ring_full is registered alongside the counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_slot_q     <= '0;
      outstanding_q <= '0;
      ring_full_q   <= 1'b0;
    end else begin
      wr_slot_q     <= wr_slot_d;
      outstanding_q <= outstanding_d;
      ring_full_q   <= ring_full_d;
    end
  end

  assign wr_slot_o   = wr_slot_q;
  assign ring_full_o = ring_full_q;

endmodule

// File: rtl/payload_dma_writer.sv
// Writes each packet's payload words into a ring of fixed-size memory slots
// and reports slot completion to the host.
module payload_dma_writer
  import dma_pkg::*;
#(
  parameter int WIDTH     = DATA_W,
  parameter int ADDR_W    = 16,
  parameter int PKT_WORDS = PAYLOAD_WORDS,
  parameter int RING_PKTS = 4,
  localparam int SLOT_W   = $clog2(RING_PKTS),
  localparam int IDX_W    = $clog2(PKT_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WIDTH-1:0]  data_in,
  input  logic              valid_in,
  output logic              ready_in,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic              cfg_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              pkt_done,
  output logic [SLOT_W-1:0] pkt_slot,
  input  logic              pkt_ack,
  output logic              ring_full
);

  dma_state_t        state_q;
  logic [ADDR_W-1:0] base_q;
  logic [IDX_W-1:0]  word_idx_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WIDTH-1:0]  mem_wdata_q;
  logic              mem_we_q;
  logic              pkt_done_q;
  logic [SLOT_W-1:0] pkt_slot_q;

  logic [SLOT_W-1:0] wr_slot;
  logic              accept;
  logic              last_word;
  logic              done_fire;
  logic [ADDR_W-1:0] wr_addr;

  // The output register acts as a one-entry buffer: a new word may enter
  // whenever the register is empty or is being drained this cycle.
  assign ready_in  = (state_q == XFER) && (!mem_we_q || mem_ready);
  assign accept    = valid_in && ready_in;
  assign last_word = (word_idx_q == IDX_W'(PKT_WORDS - 1));
  assign done_fire = (state_q == DONE) && mem_we_q && mem_ready;
  assign wr_addr   = base_q + ADDR_W'(wr_slot) * ADDR_W'(PKT_WORDS) + ADDR_W'(word_idx_q);

  dma_ring_ctrl #(
    .RING_PKTS (RING_PKTS)
  ) u_ring (
    .clk         (clk),
    .rst         (rst),
    .advance_i   (done_fire),
    .free_i      (pkt_ack),
    .wr_slot_o   (wr_slot),
    .ring_full_o (ring_full)
  );

  // Packet FSM with the write-port register and completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      base_q      <= '0;
      word_idx_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      pkt_done_q  <= 1'b0;
      pkt_slot_q  <= '0;
    end else begin
      pkt_done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cfg_en && !ring_full) begin
            base_q  <= cfg_base;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (accept) begin
            mem_addr_q  <= wr_addr;
            mem_wdata_q <= data_in;
            mem_we_q    <= 1'b1;
            word_idx_q  <= word_idx_q + IDX_W'(1);
            if (last_word) begin
              state_q <= DONE;
            end
          end else if (mem_ready) begin
            mem_we_q <= 1'b0;
          end
        end
        DONE: begin
          if (done_fire) begin
            mem_we_q   <= 1'b0;
            pkt_done_q <= 1'b1;
            pkt_slot_q <= wr_slot;
            word_idx_q <= '0;
            state_q    <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_we    = mem_we_q;
  assign pkt_done  = pkt_done_q;
  assign pkt_slot  = pkt_slot_q;

endmodule
